fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Purpose: instruction fetch sequencer; walks a 16-entry program ROM and hands words to execute.
// Latency: run/step seen in IDLE -> FETCH next cycle -> instr_valid the cycle after (1 instr / 2 cycles).
// Backpressure: instr/instr_valid/pc hold steady in HOLD until instr_ready; PC advances only on handshake.
module fetch_sequencer #(
  parameter logic [3:0] LAST_ADDR = 4'd8,
  parameter bit         WRAP      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic       halt_req,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] instr,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       jmp_en,
  input  logic [3:0] jmp_addr,
  output logic [3:0] pc,
  output logic       halted,
  output logic       wrapped
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t     state_q;
  logic [3:0] pc_q;
  logic [3:0] pc_d;
  logic [7:0] instr_q;
  logic       instr_valid_q;
  logic       halted_q;
  logic       wrapped_q;

  logic       handshake;
  logic       at_last;
  logic       wrap_event;
  logic       stop_at_end;
  logic [3:0] seq_pc;

  assign handshake   = instr_valid_q & instr_ready;
  assign at_last     = (pc_q == LAST_ADDR);
  // Sequential successor: wrap only from LAST_ADDR, otherwise plain 4-bit increment.
  assign seq_pc      = (at_last && WRAP) ? 4'd0 : pc_q + 4'd1;
  // A jump always wins over both the wrap and the end-of-program stop.
  assign wrap_event  = !jmp_en && at_last && WRAP;
  assign stop_at_end = !jmp_en && at_last && !WRAP;
  assign pc_d        = jmp_en ? jmp_addr : seq_pc;

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign wrapped     = wrapped_q;

  // Sequencer FSM with all outputs registered; reset drops any pending instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= 4'd0;
      instr_q       <= 8'h00;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      wrapped_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (halt_req) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else if (run || step) begin
            state_q <= FETCH;
          end
        end

        FETCH: begin
          instr_q       <= rom_data;
          instr_valid_q <= 1'b1;
          state_q       <= HOLD;
        end

        HOLD: begin
          if (handshake) begin
            instr_valid_q <= 1'b0;
            if (stop_at_end) begin
              // End of a non-wrapping program: PC stays parked on LAST_ADDR.
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_d;
              if (wrap_event) begin
                wrapped_q <= 1'b1;
              end
              if (halt_req) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
              end else if (run) begin
                state_q <= FETCH;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end

        HALT: begin
          halted_q <= 1'b1;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose: scoreboard bench for fetch_sequencer, wrapping and non-wrapping instances side by side.
// Latency: checks every cycle against an instruction-level reference model.
// Backpressure: instr_ready is driven directed and random to exercise HOLD stalls.
module tb_fetch_sequencer;

  localparam logic [3:0] LAST = 4'd8;

  logic       clk;
  logic       rst_n;
  logic       run, step, halt_req, instr_ready, jmp_en;
  logic [3:0] jmp_addr;

  logic [3:0] rom_addr0, pc0, rom_addr1, pc1;
  logic [7:0] rom_data0, instr0, rom_data1, instr1;
  logic       instr_valid0, halted0, wrapped0;
  logic       instr_valid1, halted1, wrapped1;

  logic [7:0] rom [16];

  assign rom_data0 = rom[rom_addr0];
  assign rom_data1 = rom[rom_addr1];

  fetch_sequencer #(.LAST_ADDR(LAST), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
    .rom_addr(rom_addr0), .rom_data(rom_data0), .instr(instr0), .instr_valid(instr_valid0),
    .instr_ready(instr_ready), .jmp_en(jmp_en), .jmp_addr(jmp_addr), .pc(pc0),
    .halted(halted0), .wrapped(wrapped0)
  );

  fetch_sequencer #(.LAST_ADDR(LAST), .WRAP(1'b0)) dut_h (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .halt_req(halt_req),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .instr(instr1), .instr_valid(instr_valid1),
    .instr_ready(instr_ready), .jmp_en(jmp_en), .jmp_addr(jmp_addr), .pc(pc1),
    .halted(halted1), .wrapped(wrapped1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: what the programmer sees -- current PC, the word on offer,
  // whether a fetch is underway, and the halted / wrapped flags.
  typedef struct packed {
    logic [3:0] pc;
    logic [7:0] instr;
    logic       valid;
    logic       fetching;
    logic       halted;
    logic       wrapped;
  } m_t;

  function automatic m_t mstep(input m_t m, input bit wrap_mode, input logic [7:0] rd,
                               input logic r_n, input logic ru, input logic st,
                               input logic hr, input logic rdy, input logic je,
                               input logic [3:0] ja);
    m_t n = m;
    if (!r_n) begin
      n = '0;
    end else if (m.halted) begin
      n = m;
    end else if (m.valid) begin
      if (rdy) begin
        n.valid = 1'b0;
        if (!je && m.pc == LAST && !wrap_mode) begin
          n.halted = 1'b1;
        end else begin
          if (je)                n.pc = ja;
          else if (m.pc == LAST) begin n.pc = 4'd0; n.wrapped = 1'b1; end
          else                   n.pc = 4'((int'(m.pc) + 1) % 16);
          if (hr)      n.halted   = 1'b1;
          else if (ru) n.fetching = 1'b1;
        end
      end
    end else if (m.fetching) begin
      n.fetching = 1'b0;
      n.valid    = 1'b1;
      n.instr    = rd;
    end else begin
      if (hr)            n.halted   = 1'b1;
      else if (ru || st) n.fetching = 1'b1;
    end
    return n;
  endfunction

  m_t m0 = '0;
  m_t m1 = '0;
  m_t n0, n1;
  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic started = 1'b0;

  assign n0 = mstep(m0, 1'b1, rom[m0.pc], rst_n, run, step, halt_req, instr_ready, jmp_en, jmp_addr);
  assign n1 = mstep(m1, 1'b0, rom[m1.pc], rst_n, run, step, halt_req, instr_ready, jmp_en, jmp_addr);

  // Model advances on the same edge as the DUTs; newly offered words go to the scoreboard.
  always @(posedge clk) begin
    if (n0.valid && !m0.valid) q0.push_back({n0.pc, n0.instr});
    if (n1.valid && !m1.valid) q1.push_back({n1.pc, n1.instr});
    m0 <= n0;
    m1 <= n1;
    if (!rst_n) started <= 1'b1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  logic       prev_v0 = 1'b0;
  logic       prev_v1 = 1'b0;
  logic [11:0] e;

  // Monitor: per-cycle state checks plus a scoreboard pop whenever a new word appears.
  always @(negedge clk) begin
    if (started) begin
      chk("w_pc", 16'(pc0), 16'(m0.pc));
      chk("w_rom_addr", 16'(rom_addr0), 16'(m0.pc));
      chk("w_valid", 16'(instr_valid0), 16'(m0.valid));
      chk("w_instr", 16'(instr0), 16'(m0.instr));
      chk("w_halted", 16'(halted0), 16'(m0.halted));
      chk("w_wrapped", 16'(wrapped0), 16'(m0.wrapped));
      chk("h_pc", 16'(pc1), 16'(m1.pc));
      chk("h_rom_addr", 16'(rom_addr1), 16'(m1.pc));
      chk("h_valid", 16'(instr_valid1), 16'(m1.valid));
      chk("h_instr", 16'(instr1), 16'(m1.instr));
      chk("h_halted", 16'(halted1), 16'(m1.halted));
      chk("h_wrapped", 16'(wrapped1), 16'(m1.wrapped));
      if (instr_valid0 === 1'b1 && !prev_v0) begin
        if (q0.size() == 0) chk("w_sb_unexpected", 16'(instr0), 16'hFFFF);
        else begin e = q0.pop_front(); chk("w_sb_word", 16'({pc0, instr0}), 16'(e)); end
      end
      if (instr_valid1 === 1'b1 && !prev_v1) begin
        if (q1.size() == 0) chk("h_sb_unexpected", 16'(instr1), 16'hFFFF);
        else begin e = q1.pop_front(); chk("h_sb_word", 16'({pc1, instr1}), 16'(e)); end
      end
    end
    prev_v0 <= (instr_valid0 === 1'b1);
    prev_v1 <= (instr_valid1 === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  // Bounded wait on the wrapping model reaching a PC while fetching or offering.
  task automatic wait_m0(input logic [3:0] p, input bit fetch_phase, input string tag);
    int k = 0;
    while (!(m0.pc == p && (fetch_phase ? m0.fetching : m0.valid)) && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (k >= 80) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_%s: condition not reached within 80 cycles", tag);
    end
  endtask

  initial begin
    rom[0]  = 8'h08; rom[1]  = 8'h19; rom[2]  = 8'h20; rom[3]  = 8'h10;
    rom[4]  = 8'h70; rom[5]  = 8'h00; rom[6]  = 8'h14; rom[7]  = 8'h04;
    rom[8]  = 8'hB2; rom[9]  = 8'h3C; rom[10] = 8'h5A; rom[11] = 8'h66;
    rom[12] = 8'h81; rom[13] = 8'h9F; rom[14] = 8'hA5; rom[15] = 8'hC3;
    rst_n = 1'b0; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    instr_ready = 1'b0; jmp_en = 1'b0; jmp_addr = 4'd0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Free run with ready high: wrap 8->0 on one instance, end-of-program halt on the other.
    run = 1'b1; instr_ready = 1'b1;
    cyc(24);
    run = 1'b0; step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(4);

    // Single step from pc 0, then idle.
    do_reset();
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(6);

    // Stall in HOLD at pc 2, then jump from pc 4 back to 1.
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    wait_m0(4'd2, 1'b1, "pc2_fetch");
    instr_ready = 1'b0;
    cyc(6);
    instr_ready = 1'b1;
    wait_m0(4'd4, 1'b0, "pc4_hold");
    jmp_en = 1'b1; jmp_addr = 4'd1;
    cyc(1);
    jmp_en = 1'b0;

    // Reset while holding the pc 5 word.
    wait_m0(4'd5, 1'b0, "pc5_hold");
    instr_ready = 1'b0;
    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    // halt_req raised during the pc 3 fetch: word 10 still delivered, then HALT at pc 4.
    instr_ready = 1'b1;
    wait_m0(4'd3, 1'b1, "pc3_fetch");
    halt_req = 1'b1;
    cyc(4);
    halt_req = 1'b0;
    step = 1'b1; jmp_en = 1'b1; jmp_addr = 4'd7;
    cyc(4);
    step = 1'b0; jmp_en = 1'b0; run = 1'b0;

    // Jump beyond LAST_ADDR: increments through 15 and rolls to 0 without marking a wrap.
    do_reset();
    run = 1'b1; instr_ready = 1'b1;
    wait_m0(4'd1, 1'b0, "pc1_hold");
    jmp_en = 1'b1; jmp_addr = 4'd13;
    cyc(1);
    jmp_en = 1'b0;
    cyc(12);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      run         = ($urandom % 3) != 0;
      step        = ($urandom % 4) == 0;
      halt_req    = ($urandom % 50) == 0;
      instr_ready = ($urandom % 3) != 0;
      jmp_en      = ($urandom % 6) == 0;
      jmp_addr    = 4'($urandom);
      rst_n       = !((($urandom % 80) == 0) || (m0.halted && ($urandom % 3) == 0));
      cyc(1);
    end

    rst_n = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
    jmp_en = 1'b0; instr_ready = 1'b1;
    cyc(6);
    chk("w_sb_leftover", 16'(q0.size()), 16'd0);
    chk("h_sb_leftover", 16'(q1.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
